song_sequencer: RTL
===================

SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 SHALL have parameter CLKF, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BEAT_HZ, default 8, ROM entries played per second.
REQ-003 SHALL have parameter NUM_SONGS, default 2, songs in ROM, legal range 1-4.
REQ-004 SHALL derive BEAT_CYC = CLKF/BEAT_HZ and GAP_CYC = BEAT_CYC/8, integer division.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port pp, input, 1 bit: play/pause switch level, asynchronous; 1 = play.
REQ-008 SHALL have port next, input, 1 bit: next-song button, asynchronous; rising edge = advance.
REQ-009 SHALL have port rom_addr, output, 8 bits: {song_idx[1:0], step[5:0]} to the note ROM.
REQ-010 SHALL have port rom_data, input, 8 bits: ROM word, valid 1 cycle after rom_addr changes; 0x00 = rest, 0xFF = end-of-song, else fullnote (octave*12+note in bits 6:0).
REQ-011 SHALL have port fullnote, output, 8 bits: held note to the tone stage.
REQ-012 SHALL have port note_valid, output, 1 bit: 1 = tone stage sounds fullnote.
REQ-013 SHALL have port song_idx, output, 2 bits: current song.
REQ-014 SHALL have port playing, output, 1 bit: 1 when synchronized pp = 1.

Function
REQ-015 SHALL pass pp and next each through a 2-flop synchronizer; next edge detected on synchronized value (one pulse per rising edge).
REQ-016 SHALL implement states FETCH, LATCH, HOLD, PAUSE.
REQ-017 FETCH: drive rom_addr for current song/step; note_valid 0; go to LATCH next cycle.
REQ-018 LATCH: sample rom_data; 0xFF -> step = 0, go FETCH (no beat consumed); 0x00 -> fullnote unchanged, rest flag set, go HOLD; other -> fullnote = rom_data, rest flag clear, go HOLD; beat counter cleared.
REQ-019 HOLD: beat counter increments each cycle; note_valid = !rest && counter < BEAT_CYC-GAP_CYC; at counter = BEAT_CYC-1, step = step+1 (6-bit wrap 63->0), go FETCH.
REQ-020 Each non-marker entry SHALL therefore occupy exactly BEAT_CYC+2 cycles; note_valid high for BEAT_CYC-GAP_CYC of them.
REQ-021 Synchronized pp = 0 in any state SHALL enter PAUSE after completing the current FETCH/LATCH pair; PAUSE freezes beat counter, step, fullnote; note_valid 0.
REQ-022 pp returning to 1 in PAUSE SHALL resume HOLD with frozen counter value (remaining beat preserved).
REQ-023 next pulse SHALL, in any state: song_idx = (song_idx+1) mod NUM_SONGS, step = 0, beat counter = 0, note_valid 0 that cycle, go FETCH if playing else PAUSE with counter 0 and fetch pending.
REQ-024 next pulse and end marker or beat end in the same cycle: next wins.
REQ-025 PAUSE with fetch pending SHALL go FETCH on resume.
REQ-026 rom_addr SHALL be registered and change only on FETCH entry.

Reset
REQ-027 rst low SHALL immediately set state FETCH, song_idx 0, step 0, beat counter 0, fullnote 0x00, note_valid 0, rom_addr 0x00, synchronizers 0, playing 0.
REQ-028 After rst release with pp = 0, SHALL enter PAUSE with fetch pending; no ROM word consumed.
REQ-029 rst asserted mid-note SHALL drop note_valid within the same cycle (asynchronous).

Verification (CLKF=1600, BEAT_HZ=100: BEAT_CYC=16, GAP_CYC=2)
REQ-030 ROM song 0 = 0x15,0x18,0xFF; pp=1 -> fullnote 0x15 with note_valid high 14 cycles, low 4, then 0x18, then wrap to address 0x00.
REQ-031 Entry 0x00 between notes -> note_valid low for 18 cycles, fullnote holds previous value.
REQ-032 pp dropped 5 cycles into HOLD for 100 cycles -> note_valid 0 throughout, then high 9 more cycles after resume.
REQ-033 next pulsed in song 1 (NUM_SONGS=2) -> song_idx 0, rom_addr 0x00 within 4 cycles of the edge (2 sync + 1 detect + 1 register).
REQ-034 next coincident with 0xFF in LATCH -> song_idx advances, step 0, no extra wrap fetch of old song.
REQ-035 rst low mid-HOLD -> all outputs at REQ-027 values same cycle; after release, playback restarts from song 0 step 0.

Source files
------------

// File: rtl/song_sequencer.sv
// song_sequencer: steps through a note ROM one entry per beat and holds the
// current note for the tone stage.
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   rst         asynchronous active-low reset
//   pp          play/pause switch level (asynchronous), 1 = play
//   next        next-song button (asynchronous), rising edge advances the song
//   rom_addr    registered ROM address {song_idx, step}
//   rom_data    ROM word, valid one cycle after rom_addr changes
//                 0x00 = rest, 0xFF = end-of-song, otherwise a note number
//   fullnote    note currently held for the tone stage
//   note_valid  tone stage sounds fullnote while high
//   song_idx    current song
//   playing     synchronized pp
module song_sequencer #(
    parameter int unsigned CLKF      = 100_000_000,
    parameter int unsigned BEAT_HZ   = 8,
    parameter int unsigned NUM_SONGS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pp,
    input  logic       next,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [7:0] fullnote,
    output logic       note_valid,
    output logic [1:0] song_idx,
    output logic       playing
);

    localparam int unsigned BEAT_CYC = CLKF / BEAT_HZ;
    localparam int unsigned GAP_CYC  = BEAT_CYC / 8;
    localparam int unsigned CW       = (BEAT_CYC > 1) ? $clog2(BEAT_CYC) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(BEAT_CYC - 1);
    // One extra bit so a zero gap (very short beats) cannot wrap the threshold.
    localparam logic [CW:0]   CNT_ON   = (CW + 1)'(BEAT_CYC - GAP_CYC);
    localparam logic [1:0]    SONG_LAST = 2'(NUM_SONGS - 1);

    typedef enum logic [1:0] {StFetch, StLatch, StHold, StPause} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_pp_meta, r_pp_sync;
    logic          r_nx_meta, r_nx_sync, r_nx_prev;
    logic          w_next_pulse;
    logic [1:0]    r_song, w_song_nxt;
    logic [5:0]    r_step, w_step_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [7:0]    r_note, w_note_nxt;
    logic          r_rest, w_rest_nxt;
    logic          r_pend, w_pend_nxt;
    logic [7:0]    r_rom_addr;

    // Input synchronizers; r_nx_prev gives a single-cycle pulse per rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pp_meta <= 1'b0;
            r_pp_sync <= 1'b0;
            r_nx_meta <= 1'b0;
            r_nx_sync <= 1'b0;
            r_nx_prev <= 1'b0;
        end else begin
            r_pp_meta <= pp;
            r_pp_sync <= r_pp_meta;
            r_nx_meta <= next;
            r_nx_sync <= r_nx_meta;
            r_nx_prev <= r_nx_sync;
        end
    end

    assign w_next_pulse = r_nx_sync & ~r_nx_prev;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_song     <= 2'd0;
            r_step     <= 6'd0;
            r_cnt      <= '0;
            r_note     <= 8'h00;
            r_rest     <= 1'b0;
            r_pend     <= 1'b0;
            r_rom_addr <= 8'h00;
        end else begin
            r_song <= w_song_nxt;
            r_step <= w_step_nxt;
            r_cnt  <= w_cnt_nxt;
            r_note <= w_note_nxt;
            r_rest <= w_rest_nxt;
            r_pend <= w_pend_nxt;
            // Address only moves when (re)entering FETCH.
            if (w_state_nxt == StFetch) begin
                r_rom_addr <= {w_song_nxt, w_step_nxt};
            end
        end
    end

    // Next-state and datapath next values
    always_comb begin
        w_state_nxt = r_state;
        w_song_nxt  = r_song;
        w_step_nxt  = r_step;
        w_cnt_nxt   = r_cnt;
        w_note_nxt  = r_note;
        w_rest_nxt  = r_rest;
        w_pend_nxt  = r_pend;

        if (w_next_pulse) begin
            // Song change overrides any end marker or beat end this cycle.
            w_song_nxt = (r_song == SONG_LAST) ? 2'd0 : r_song + 2'd1;
            w_step_nxt = 6'd0;
            w_cnt_nxt  = '0;
            if (r_pp_sync) begin
                w_state_nxt = StFetch;
                w_pend_nxt  = 1'b0;
            end else begin
                w_state_nxt = StPause;
                w_pend_nxt  = 1'b1;
            end
        end else begin
            case (r_state)
                StFetch: begin
                    // Paused before the ROM word is consumed: refetch on resume.
                    if (r_pp_sync) begin
                        w_state_nxt = StLatch;
                    end else begin
                        w_state_nxt = StPause;
                        w_pend_nxt  = 1'b1;
                    end
                end
                StLatch: begin
                    w_cnt_nxt = '0;
                    if (rom_data == 8'hFF) begin
                        w_step_nxt  = 6'd0;
                        w_state_nxt = StFetch;
                    end else begin
                        if (rom_data == 8'h00) begin
                            w_rest_nxt = 1'b1;
                        end else begin
                            w_note_nxt = rom_data;
                            w_rest_nxt = 1'b0;
                        end
                        w_pend_nxt  = 1'b0;
                        w_state_nxt = r_pp_sync ? StHold : StPause;
                    end
                end
                StHold: begin
                    if (!r_pp_sync) begin
                        w_state_nxt = StPause;
                    end else if (r_cnt == CNT_LAST) begin
                        w_step_nxt  = r_step + 6'd1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = StFetch;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                StPause: begin
                    if (r_pp_sync) begin
                        w_state_nxt = r_pend ? StFetch : StHold;
                        w_pend_nxt  = 1'b0;
                    end
                end
                default: w_state_nxt = StFetch;
            endcase
        end
    end

    // Outputs
    always_comb begin
        note_valid = (r_state == StHold) && r_pp_sync && !r_rest && !w_next_pulse &&
                     ({1'b0, r_cnt} < CNT_ON);
    end

    assign rom_addr = r_rom_addr;
    assign fullnote = r_note;
    assign song_idx = r_song;
    assign playing  = r_pp_sync;

endmodule
